// File: rtl/wb_mem_2_ppfifo_mb_if.sv
// Bus bundle between the multi-bank reader, the memory arbiter (Wishbone,
// read-only) and a ping-pong FIFO write port.
interface wb_mem_2_ppfifo_mb_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_SIZE_WIDTH = 24
);
    logic                       mem_we;
    logic                       mem_stb;
    logic                       mem_cyc;
    logic [DATA_WIDTH/8-1:0]    mem_sel;
    logic [31:0]                mem_adr;
    logic [DATA_WIDTH-1:0]      mem_wdat;
    logic [DATA_WIDTH-1:0]      mem_rdat;
    logic                       mem_ack;
    logic [1:0]                 ppfifo_rdy;
    logic [1:0]                 ppfifo_act;
    logic [FIFO_SIZE_WIDTH-1:0] ppfifo_size;
    logic                       ppfifo_stb;
    logic [DATA_WIDTH-1:0]      ppfifo_data;

    modport master (
        output mem_we, mem_stb, mem_cyc, mem_sel, mem_adr, mem_wdat,
        input  mem_rdat, mem_ack,
        input  ppfifo_rdy, ppfifo_size,
        output ppfifo_act, ppfifo_stb, ppfifo_data
    );

    modport slave (
        input  mem_we, mem_stb, mem_cyc, mem_sel, mem_adr, mem_wdat,
        output mem_rdat, mem_ack,
        output ppfifo_rdy, ppfifo_size,
        input  ppfifo_act, ppfifo_stb, ppfifo_data
    );
endinterface

// File: rtl/wb_mem_2_ppfifo_mb.sv
// Multi-bank Wishbone memory reader feeding a ping-pong FIFO writer.
// Banks are drained round-robin; circular mode rewinds a bank once consumed.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | core disabled, bus quiet
//   SELECT | round-robin scan for the next bank with words remaining
//   READ   | single-beat reads from the active bank into the FIFO half
//   DONE   | active bank consumed: flush partial FIFO block, optional rewind
module wb_mem_2_ppfifo_mb #(
    parameter int NUM_BANKS       = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_STRIDE     = 1,
    parameter int FIFO_SIZE_WIDTH = 24,
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   circular,
    input  logic [32*NUM_BANKS-1:0] bank_base,
    input  logic [32*NUM_BANKS-1:0] bank_size,
    input  logic [NUM_BANKS-1:0]   bank_new_data,
    output logic [32*NUM_BANKS-1:0] bank_count,
    output logic [NUM_BANKS-1:0]   bank_empty,
    output logic [NUM_BANKS-1:0]   bank_done,
    output logic [BW-1:0]          active_bank,
    output logic                   busy,
    wb_mem_2_ppfifo_mb_if.master   bus
);
    typedef enum logic [1:0] {IDLE, SELECT, READ, DONE} state_t;

    state_t                     state;
    logic [31:0]                ptr   [NUM_BANKS];
    logic [31:0]                count [NUM_BANKS];
    logic [BW-1:0]              last;
    logic [BW-1:0]              active;
    logic [1:0]                 act;
    logic [FIFO_SIZE_WIDTH-1:0] fifo_cnt;
    logic                       cyc;
    logic                       stb;
    logic                       fstb;
    logic [DATA_WIDTH-1:0]      fdata;
    logic [NUM_BANKS-1:0]       done;
    logic [31:0]                count_a;
    logic                       sel_found;
    logic [BW-1:0]              sel_idx;

    // A pointer past a shrunken size reads as empty rather than wrapping.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign count[b] = (ptr[b] >= bank_size[b*32 +: 32]) ? 32'd0
                                                            : bank_size[b*32 +: 32] - ptr[b];
        assign bank_count[b*32 +: 32] = count[b];
        assign bank_empty[b]          = (count[b] == 32'd0);
    end

    assign count_a      = count[active];
    assign bus.mem_adr  = bank_base[active*32 +: 32] + ptr[active] * 32'(ADDR_STRIDE);
    assign bus.mem_we   = 1'b0;
    assign bus.mem_sel  = '1;
    assign bus.mem_wdat = '0;
    assign bus.mem_cyc  = cyc;
    assign bus.mem_stb  = stb;
    assign bus.ppfifo_act  = act;
    assign bus.ppfifo_stb  = fstb;
    assign bus.ppfifo_data = fdata;
    assign bank_done    = done;
    assign active_bank  = active;
    assign busy         = (state != IDLE);

    // Round-robin pick: first non-empty bank after the last one served.
    always_comb begin
        int j;
        j         = 0;
        sel_found = 1'b0;
        sel_idx   = last;
        for (int i = 1; i <= NUM_BANKS; i++) begin
            j = (int'(last) + i) % NUM_BANKS;
            if (!sel_found && count[j] != 32'd0) begin
                sel_found = 1'b1;
                sel_idx   = BW'(j);
            end
        end
    end

    // Sequencer, FIFO half ownership and per-bank read pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= BW'(NUM_BANKS - 1);
            active   <= '0;
            act      <= 2'b00;
            fifo_cnt <= '0;
            cyc      <= 1'b0;
            stb      <= 1'b0;
            fstb     <= 1'b0;
            fdata    <= '0;
            done     <= '0;
            for (int b = 0; b < NUM_BANKS; b++) ptr[b] <= 32'd0;
        end else begin
            fstb <= 1'b0;
            done <= '0;
            if (enable && act == 2'b00 && bus.ppfifo_rdy != 2'b00) begin
                act      <= bus.ppfifo_rdy[0] ? 2'b01 : 2'b10;
                fifo_cnt <= '0;
            end
            case (state)
                IDLE: begin
                    cyc <= 1'b0;
                    stb <= 1'b0;
                    if (enable) state <= SELECT;
                end
                SELECT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (sel_found) begin
                        active <= sel_idx;
                        last   <= sel_idx;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (stb) begin
                        // An issued beat always completes, even if enable drops.
                        if (bus.mem_ack) begin
                            fdata       <= bus.mem_rdat;
                            fstb        <= 1'b1;
                            ptr[active] <= ptr[active] + 32'd1;
                            fifo_cnt    <= fifo_cnt + FIFO_SIZE_WIDTH'(1);
                            stb         <= 1'b0;
                            cyc         <= 1'b0;
                            if (!enable) begin
                                act   <= 2'b00;
                                state <= IDLE;
                            end
                        end
                    end else if (!enable) begin
                        cyc <= 1'b0;
                        if (fifo_cnt != '0) act <= 2'b00;
                        state <= IDLE;
                    end else if (count_a == 32'd0) begin
                        done[active] <= 1'b1;
                        state        <= DONE;
                    end else if (act == 2'b00) begin
                        cyc <= 1'b0;
                    end else if (fifo_cnt >= bus.ppfifo_size) begin
                        act <= 2'b00;
                    end else begin
                        cyc <= 1'b1;
                        stb <= 1'b1;
                    end
                end
                DONE: begin
                    if (fifo_cnt != '0) begin
                        act      <= 2'b00;
                        fifo_cnt <= '0;
                    end
                    if (circular) ptr[active] <= 32'd0;
                    state <= SELECT;
                end
                default: state <= IDLE;
            endcase
            // Re-arm wins over a same-cycle increment or rewind.
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_new_data[b]) ptr[b] <= 32'd0;
            end
        end
    end
endmodule

// File: doc/wb_mem_2_ppfifo_mb.md
# wb_mem_2_ppfifo_mb

Multi-bank, parametrised Wishbone-memory-to-ping-pong-FIFO reader. It drains up to NUM_BANKS independently described memory regions into a single ping-pong FIFO writer. Banks are served round-robin, and an optional circular mode re-arms each bank automatically. It sits between the memory arbiter (as a read-only Wishbone master) and a ppfifo write port, replacing the fixed two-bank reader in streaming paths such as video and DMA.

## Interface
- NUM_BANKS, 2: number of memory regions, 1..8; BW = max(1, clog2(NUM_BANKS))
- DATA_WIDTH, 32: Wishbone and FIFO data width, multiple of 8
- ADDR_STRIDE, 1: address increment per word (1 = word addressing, 4 = byte addressing)
- FIFO_SIZE_WIDTH, 24: width of i_ppfifo_size and the internal FIFO counter

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- i_enable  in  1  core enable
- i_circular  in  1  1 = a bank's pointer rewinds to 0 when it completes
- i_bank_base  in  32*NUM_BANKS  word-address base per bank; bank b at [32b+31:32b]
- i_bank_size  in  32*NUM_BANKS  size in words per bank
- i_bank_new_data  in  NUM_BANKS  pulse: reset bank pointer to 0
- o_bank_count  out  32*NUM_BANKS  words remaining per bank
- o_bank_empty  out  NUM_BANKS  1 when count == 0
- o_bank_done  out  NUM_BANKS  one-cycle pulse when a bank is fully consumed
- o_active_bank  out  BW  bank currently selected
- o_busy  out  1  state != IDLE
- o_mem_we, o_mem_stb, o_mem_cyc  out  1 each  Wishbone master controls
- o_mem_sel  out  DATA_WIDTH/8  byte select
- o_mem_adr  out  32  address
- o_mem_dat  out  DATA_WIDTH  write data, constant 0
- i_mem_dat  in  DATA_WIDTH  read data
- i_mem_ack  in  1  Wishbone ack
- i_ppfifo_rdy  in  2  FIFO halves ready
- o_ppfifo_act  out  2  FIFO half activate
- i_ppfifo_size  in  FIFO_SIZE_WIDTH  capacity of a FIFO half
- o_ppfifo_stb  out  1  write strobe
- o_ppfifo_data  out  DATA_WIDTH  registered write data

## Operation
- **Reset values:**
  - o_mem_sel = all ones.
  - All other outputs are 0, including o_mem_we, which stays 0 permanently.
  - All bank pointers = 0; state = IDLE.
  - Round-robin last-served index = NUM_BANKS-1, so bank 0 is served first.
- **Bank status:**
  - count[b] = (ptr[b] >= size[b]) ? 0 : size[b] - ptr[b]. There is no underflow when size shrinks below ptr.
  - o_mem_adr = base[a] + ptr[a]*ADDR_STRIDE, where a = active bank; computed combinationally.
- **FIFO acquire:** when i_enable, act == 0 and rdy != 0: act <= rdy[0] ? 2'b01 : 2'b10, and the FIFO counter is set to 0.
- **IDLE:** cyc = stb = 0. When i_enable = 1, go to SELECT.
- **SELECT:**
  - If i_enable = 0, go to IDLE.
  - Otherwise scan banks starting at (last+1) mod NUM_BANKS and take the first with count != 0; set active bank and last = that bank, then go to READ.
  - If no bank has data, stay in SELECT.
- **READ, stb/cyc assertion:** cyc = stb = 1 only while all of the following hold: act != 0, FIFO counter < i_ppfifo_size, count[a] != 0.
- **READ, on ack & stb:**
  - o_ppfifo_data <= i_mem_dat; o_ppfifo_stb <= 1.
  - ptr[a]++ and FIFO counter++.
  - stb <= 0 for one cycle. Single-beat classic cycles only.
- **READ, FIFO full** (counter == size, including i_ppfifo_size == 0): cyc = stb = 0 and act <= 0; re-acquire per the rule above.
- **READ, act == 0:** cyc = stb = 0; wait.
- **READ, count[a] == 0 with no outstanding stb:** go to DONE.
- **READ, i_enable falls:**
  - If stb is asserted, wait for ack and complete that word.
  - Then drop cyc; if the FIFO counter > 0, set act <= 0 (flush). Go to IDLE.
- **DONE:**
  - o_bank_done[a] pulses for 1 cycle.
  - If the FIFO counter > 0, act <= 0 and counter <= 0 (flush partial block).
  - If i_circular = 1, ptr[a] <= 0.
  - Go to SELECT.
- **i_bank_new_data[b]:** ptr[b] <= 0. This has priority over the increment in the same cycle. If the ack lands in that cycle, the word is still written to the FIFO.
- **Reset mid-operation:** all outputs return to reset values at the next edge. A late ack is ignored and no FIFO strobe is issued.

## Timing
- **SELECT to first stb:** 1 cycle (stb high in the cycle after the SELECT→READ edge).
- **ack to o_ppfifo_stb:** 1 cycle; data and stb are registered together.
- **Throughput:** 1 word per 2 cycles with zero-wait-state ack.
- **o_bank_done to next bank's first stb:** 3 cycles (DONE→SELECT→READ→stb).
- **o_bank_count / o_bank_empty:** combinational from the pointers; update the cycle after the ack.
- **FIFO full to act release:** act low 1 cycle after the final strobe.

## Test plan
- **Basic drain:** NUM_BANKS=2, bank0 base 0x100 size 4, bank1 size 0, FIFO size 8, ack 1 cycle after stb → adr 0x100..0x103, 4 FIFO strobes with matching data, o_bank_done[0] pulse, then act released with counter 4.
- **Round-robin:** NUM_BANKS=4, all banks size 2 → bank service order 0,1,2,3. Re-arm bank 0 via new_data → next served after bank 3, never out of order.
- **FIFO boundary:** bank size 10, FIFO size 4 → act released after 4th and 8th strobes, 3 acquisitions total, 10 strobes, no stb while act == 0.
- **Circular + stride:** ADDR_STRIDE=4, i_circular=1, size 3, base 0 → adr 0,4,8, done pulse, then adr 0,4,8 again.
- **Disable mid-transfer:** drop i_enable while stb is pending, ack 3 cycles later → word written, cyc low next cycle, IDLE, act released.
- **Reset/new_data collisions:** new_data with ack in the same cycle → ptr = 0, strobe issued. rst with stb pending → all outputs reset, no strobe on late ack.
